char_buffer_writer: RTL and testbench

Formats per-channel voltage readings into ASCII text and writes them into the character buffer RAM. `vga_draw_char` reads that buffer through its `text_xy` address to draw the 12-column x 13-row voltage table. The block is the write end of the character-buffer interface: one 12-character row per channel, `"CHnn: d.dddV"`. It accepts one millivolt sample at a time over a valid/ready handshake, converts it to BCD sequentially, then emits 12 single-cycle RAM writes.

---
 rtl/char_buffer_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_char_buffer_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_writer.sv
// char_buffer_writer: formats one millivolt reading per channel as the text
// row "CHnn: d.dddV" and writes it, one character per cycle, into the
// character buffer RAM that vga_draw_char scans.
// Optional feature macro: CHAR_BUFFER_INIT_EN -- after reset, fill every row
// with its "CHnn: 0.000V" template before accepting samples.
module char_buffer_writer #(
   parameter int BASE_ADDR = 0,
   parameter int NUM_CH    = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_ch,
   input  logic [13:0] in_mv,
   output logic        wr_en,
   output logic [7:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        done,
   output logic        err
);

   localparam logic [7:0]  BASE_ADDR_W = 8'(BASE_ADDR);
   localparam logic [4:0]  NUM_CH_W    = 5'(NUM_CH);
   localparam logic [13:0] MV_MAX      = 14'd9999;

   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_WRITE, ST_INIT} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  col_reg, col_next;
   logic [3:0]  ch_reg;
   logic [13:0] bin_reg;
   logic [15:0] bcd_reg;
   logic [3:0]  bit_cnt_reg;

   logic        in_ready_reg, in_ready_next;
   logic        wr_en_reg, wr_en_next;
   logic [7:0]  wr_addr_reg, wr_addr_next;
   logic [7:0]  wr_data_reg, wr_data_next;
   logic        done_reg, done_next;
   logic        err_reg, err_next;

   logic        accept;
   logic        ch_ok;
   logic [13:0] mv_clamped;
   logic [15:0] bcd_adj;
   logic [7:0]  row_base;

`ifdef CHAR_BUFFER_INIT_EN
   localparam logic [7:0] INIT_LAST = 8'(NUM_CH * 12 - 1);
   logic [7:0] init_cnt_reg;
   logic [3:0] init_row_reg;
   logic [3:0] init_col_reg;
`endif

   // Character at a given column of a row; num is the 1-based channel number.
   function automatic logic [7:0] row_char(input logic [3:0] col,
                                           input logic [4:0] num,
                                           input logic [15:0] bcd);
      logic [4:0] ones;
      ones = (num >= 5'd10) ? num - 5'd10 : num;
      case (col)
         4'd0:    row_char = 8'h43;
         4'd1:    row_char = 8'h48;
         4'd2:    row_char = (num >= 5'd10) ? 8'h31 : 8'h30;
         4'd3:    row_char = 8'h30 + {3'b000, ones};
         4'd4:    row_char = 8'h3A;
         4'd5:    row_char = 8'h20;
         4'd6:    row_char = 8'h30 + {4'h0, bcd[15:12]};
         4'd7:    row_char = 8'h2E;
         4'd8:    row_char = 8'h30 + {4'h0, bcd[11:8]};
         4'd9:    row_char = 8'h30 + {4'h0, bcd[7:4]};
         4'd10:   row_char = 8'h30 + {4'h0, bcd[3:0]};
         4'd11:   row_char = 8'h56;
         default: row_char = 8'h20;
      endcase
   endfunction

   assign accept     = (state_reg == ST_IDLE) && in_valid && in_ready_reg;
   assign ch_ok      = ({1'b0, in_ch} < NUM_CH_W);
   assign mv_clamped = (in_mv > MV_MAX) ? MV_MAX : in_mv;
   assign row_base   = BASE_ADDR_W + {1'b0, ch_reg, 3'b000} + {2'b00, ch_reg, 2'b00};

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dabble
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // State register and column counter.
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef CHAR_BUFFER_INIT_EN
         state_reg <= ST_INIT;
`else
         state_reg <= ST_IDLE;
`endif
         col_reg <= 4'd0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
      end
   end

   // Next-state logic: accept, convert for 14 cycles, write 12 columns.
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept && ch_ok) state_next = ST_CONV;
         end
         ST_CONV: begin
            if (bit_cnt_reg == 4'd13) begin
               state_next = ST_WRITE;
               col_next   = 4'd0;
            end
         end
         ST_WRITE: begin
            if (col_reg == 4'd11) state_next = ST_IDLE;
            else                  col_next   = col_reg + 4'd1;
         end
`ifdef CHAR_BUFFER_INIT_EN
         ST_INIT: begin
            if (init_cnt_reg == INIT_LAST) state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic: values for the coming cycle, registered below.
   always_comb begin
      wr_en_next    = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;
      done_next     = 1'b0;
      err_next      = accept && !ch_ok;
      in_ready_next = (state_next == ST_IDLE);
`ifdef CHAR_BUFFER_INIT_EN
      // Hold off one cycle so ready rises after the last template write.
      if (state_reg == ST_INIT) in_ready_next = 1'b0;
`endif
      if (state_next == ST_WRITE) begin
         wr_en_next   = 1'b1;
         wr_addr_next = row_base + {4'h0, col_next};
         wr_data_next = row_char(col_next, {1'b0, ch_reg} + 5'd1, bcd_reg);
         done_next    = (col_next == 4'd11);
      end
`ifdef CHAR_BUFFER_INIT_EN
      if (state_reg == ST_INIT) begin
         wr_en_next   = 1'b1;
         wr_addr_next = BASE_ADDR_W + init_cnt_reg;
         wr_data_next = row_char(init_col_reg, {1'b0, init_row_reg} + 5'd1, 16'h0000);
      end
`endif
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef CHAR_BUFFER_INIT_EN
         in_ready_reg <= 1'b0;
`else
         in_ready_reg <= 1'b1;
`endif
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= 8'h00;
         wr_data_reg <= 8'h00;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         in_ready_reg <= in_ready_next;
         wr_en_reg    <= wr_en_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   // Sample capture and one-bit-per-cycle binary-to-BCD conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_reg      <= 4'd0;
         bin_reg     <= 14'd0;
         bcd_reg     <= 16'h0000;
         bit_cnt_reg <= 4'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept && ch_ok) begin
                  ch_reg      <= in_ch;
                  bin_reg     <= mv_clamped;
                  bcd_reg     <= 16'h0000;
                  bit_cnt_reg <= 4'd0;
               end
            end
            ST_CONV: begin
               bcd_reg     <= {bcd_adj[14:0], bin_reg[13]};
               bin_reg     <= {bin_reg[12:0], 1'b0};
               bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef CHAR_BUFFER_INIT_EN
   // Template fill counters: linear address plus row/column position.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt_reg <= 8'd0;
         init_row_reg <= 4'd0;
         init_col_reg <= 4'd0;
      end else if (state_reg == ST_INIT) begin
         init_cnt_reg <= init_cnt_reg + 8'd1;
         if (init_col_reg == 4'd11) begin
            init_col_reg <= 4'd0;
            init_row_reg <= init_row_reg + 4'd1;
         end else begin
            init_col_reg <= init_col_reg + 4'd1;
         end
      end
   end
`endif

   assign in_ready = in_ready_reg;
   assign wr_en    = wr_en_reg;
   assign wr_addr  = wr_addr_reg;
   assign wr_data  = wr_data_reg;
   assign done     = done_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Testbench for char_buffer_writer: a driver issues samples and queues the
// expected text-row writes; an independent monitor checks every write.
module tb_char_buffer_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  in_ch = 4'd0;
   logic [13:0] in_mv = 14'd0;
   logic        in_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        done;
   logic        err;

   char_buffer_writer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ch    (in_ch),
      .in_mv    (in_mv),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far; at a falling edge it is the index
   // of the next rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int addr;
      int data;
      int last;
      int cyc;
   } wr_t;

   wr_t wr_q[$];
   int  err_q[$];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference text of a row, straight from the display format.
   function automatic string row_text(input int ch, input int mv);
      int v;
      v = (mv > 9999) ? 9999 : mv;
      return $sformatf("CH%02d: %0d.%03dV", ch + 1, v / 1000, v % 1000);
   endfunction

   // Present a sample, wait for acceptance, queue expected results.
   // Called and returns at a falling edge; a = acceptance edge index.
   task automatic send(input int ch, input int mv, input bit keep,
                       input int ncols, output int a);
      string s;
      int    guard;
      wr_t   e;
      in_valid = 1'b1;
      in_ch    = 4'(ch);
      in_mv    = 14'(mv);
      guard    = 0;
      while (!in_ready && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         a = -1;
         return;
      end
      a = cyc;
      if (ch < 13) begin
         s = row_text(ch, mv);
         for (int col = 0; col < ncols; col++) begin
            e.addr = ch * 12 + col;
            e.data = int'(s[col]);
            e.last = (col == 11) ? 1 : 0;
            e.cyc  = a + 15 + col;
            wr_q.push_back(e);
         end
      end else begin
         err_q.push_back(a + 1);
      end
      $display("sample ch=%0d mv=%0d accepted at cycle %0d row \"%s\"",
               ch, mv, a, (ch < 13) ? row_text(ch, mv) : "(dropped)");
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
   endtask

   // Wait for in_ready to return and check when it did.
   task automatic wait_ready(input int a);
      int guard;
      guard = 0;
      while (!in_ready && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("ready_latency", cyc - a, 27);
   endtask

   // Monitor: every write and every err pulse must match the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (mon_en) begin
         if (wr_en) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
               e = wr_q.pop_front();
               check("wr_addr", int'(wr_addr), e.addr);
               check("wr_data", int'(wr_data), e.data);
               check("done", int'(done), e.last);
               check("wr_cycle", cyc, e.cyc);
               $display("write cycle %0d addr %0d data 0x%02h done %0d",
                        cyc, wr_addr, wr_data, done);
            end
         end else if (done) begin
            check("done_without_write", int'(done), 0);
         end
         if (err_q.size() > 0 && err_q[0] < cyc) begin
            check("err_missing_cycle", cyc, err_q[0]);
            void'(err_q.pop_front());
         end
         if (err_q.size() > 0 && err_q[0] == cyc) begin
            check("err_pulse", int'(err), 1);
            void'(err_q.pop_front());
         end else if (err) begin
            check("unexpected_err", int'(err), 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a2, ch, mv, guard;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_wr_en", int'(wr_en), 0);
      check("reset_wr_addr", int'(wr_addr), 0);
      check("reset_wr_data", int'(wr_data), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      check("reset_in_ready", int'(in_ready), 1);
      mon_en = 1'b1;

      // Directed rows and boundaries.
      send(0, 1234, 1'b0, 12, a);
      wait_ready(a);
      send(12, 0, 1'b0, 12, a);
      wait_ready(a);
      send(3, 12000, 1'b0, 12, a);
      wait_ready(a);
      send(13, 500, 1'b0, 12, a);
      check("err_in_ready", int'(in_ready), 1);
      send(15, 9999, 1'b0, 12, a);
      check("err_in_ready", int'(in_ready), 1);

      // Back-to-back samples with in_valid held high.
      send(5, 4321, 1'b1, 12, a1);
      send(6, 9999, 1'b0, 12, a2);
      check("b2b_spacing", a2 - a1, 27);
      wait_ready(a2);

      // Randomized samples including clamp boundaries and bad channels.
      for (int i = 0; i < 24; i++) begin
         ch = int'($urandom_range(0, 14));
         case ($urandom_range(0, 4))
            0:       mv = 9999;
            1:       mv = 10000;
            2:       mv = 16383;
            default: mv = int'($urandom_range(0, 16383));
         endcase
         send(ch, mv, 1'b0, 12, a);
         if (ch < 13) wait_ready(a);
         else         check("err_in_ready", int'(in_ready), 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset in cycle 20 of a row: only columns 0..5 reach the RAM.
      send(7, 2500, 1'b0, 6, a);
      guard = 0;
      while (cyc < a + 20 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("reset_mid_wr_en", int'(wr_en), 0);
      @(negedge clk);
      check("reset_mid_in_ready", int'(in_ready), 1);
      repeat (30) @(negedge clk);

      // Drain and confirm nothing expected is still outstanding.
      guard = 0;
      while ((wr_q.size() != 0 || err_q.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("pending_writes", wr_q.size(), 0);
      check("pending_errs", err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
